// File: rtl/ft245_fifo_if_pkg.sv
// Shared types and default timing for the FT245 asynchronous FIFO front end.
package ft245_fifo_if_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LOW,
        RD_HIGH,
        WR_SETUP,
        WR_HIGH,
        WR_HOLD
    } ft_state_t;

    // Defaults assume a 100 MHz system clock.
    localparam int FT_RD_LOW_CYCLES   = 5;
    localparam int FT_RD_HIGH_CYCLES  = 3;
    localparam int FT_WR_SETUP_CYCLES = 1;
    localparam int FT_WR_HIGH_CYCLES  = 5;
    localparam int FT_WR_HOLD_CYCLES  = 3;
    localparam int FT_SYNC_STAGES     = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser with a selectable reset level.
module sync_ff #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stage;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage <= {DEPTH{RESET_VAL}};
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/ft245_fifo_if.sv
// FT245 pin sequencer: RD#/WR strobe timing, data bus enable and RX/TX
// valid/ready streams with round-robin arbitration between the two.
module ft245_fifo_if
    import ft245_fifo_if_pkg::*;
#(
    parameter int RD_LOW_CYCLES   = FT_RD_LOW_CYCLES,
    parameter int RD_HIGH_CYCLES  = FT_RD_HIGH_CYCLES,
    parameter int WR_SETUP_CYCLES = FT_WR_SETUP_CYCLES,
    parameter int WR_HIGH_CYCLES  = FT_WR_HIGH_CYCLES,
    parameter int WR_HOLD_CYCLES  = FT_WR_HOLD_CYCLES,
    parameter int SYNC_STAGES     = FT_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       FT_RX_Full_n,
    input  logic       FT_TX_Enable_n,
    input  logic       FT_PWR_n,
    output logic       FT_RD_Strobe_n,
    output logic       FT_WR_Strobe,
    input  logic [7:0] ft_data_in,
    output logic [7:0] ft_data_out,
    output logic       ft_data_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       usb_active,
    output logic       usb_power
);

    localparam int MAX_CYCLES = max_int(max_int(max_int(RD_LOW_CYCLES, RD_HIGH_CYCLES),
                                                max_int(WR_SETUP_CYCLES, WR_HIGH_CYCLES)),
                                        WR_HOLD_CYCLES);
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] RD_LOW_LOAD   = CNT_W'(RD_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_HIGH_LOAD  = CNT_W'(RD_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_SETUP_LOAD = CNT_W'(WR_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_HIGH_LOAD  = CNT_W'(WR_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_HOLD_LOAD  = CNT_W'(WR_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    // Recovery phases must outlast the flag synchronisers, or a stale flag is re-read.
    if (RD_LOW_CYCLES < 1 || RD_HIGH_CYCLES < 1 || WR_SETUP_CYCLES < 1 ||
        WR_HIGH_CYCLES < 1 || WR_HOLD_CYCLES < 1 || SYNC_STAGES < 1) begin : g_bad_zero
        $error("ft245_fifo_if: timing parameters and SYNC_STAGES must be >= 1");
    end
    if (RD_HIGH_CYCLES < SYNC_STAGES + 1 || WR_HOLD_CYCLES < SYNC_STAGES + 1) begin : g_bad_recovery
        $error("ft245_fifo_if: RD_HIGH_CYCLES and WR_HOLD_CYCLES must be >= SYNC_STAGES+1");
    end

    ft_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             last_rx;
    logic             rxf_sync;
    logic             txe_sync;
    logic             pwr_sync;
    logic             pwr_ok;
    logic             rxf_ok;
    logic             txe_ok;
    logic             want_tx;
    logic             grant_rx;
    logic             grant_tx;

    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rxf (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (FT_RX_Full_n),
        .q       (rxf_sync)
    );

    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_txe (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (FT_TX_Enable_n),
        .q       (txe_sync)
    );

    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_pwr (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (FT_PWR_n),
        .q       (pwr_sync)
    );

    assign pwr_ok    = ~pwr_sync;
    assign usb_power = pwr_ok;
    assign rxf_ok    = ~rxf_sync & pwr_ok & ~rx_valid;
    assign txe_ok    = ~txe_sync & pwr_ok;
    assign want_tx   = txe_ok & tx_valid;

    // When both directions are pending, the one not served last wins.
    assign grant_rx  = rxf_ok & (~want_tx | ~last_rx);
    assign grant_tx  = want_tx & (~rxf_ok | last_rx);
    assign tx_ready  = (state == IDLE) & grant_tx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            last_rx        <= 1'b0;
            FT_RD_Strobe_n <= 1'b1;
            FT_WR_Strobe   <= 1'b0;
            ft_data_out    <= '0;
            ft_data_oe     <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            usb_active     <= 1'b0;
        end else begin
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (grant_rx) begin
                        state          <= RD_LOW;
                        cnt            <= RD_LOW_LOAD;
                        FT_RD_Strobe_n <= 1'b0;
                        usb_active     <= 1'b1;
                        last_rx        <= 1'b1;
                    end else if (grant_tx) begin
                        state        <= WR_SETUP;
                        cnt          <= WR_SETUP_LOAD;
                        ft_data_out  <= tx_data;
                        ft_data_oe   <= 1'b1;
                        FT_WR_Strobe <= 1'b0;
                        usb_active   <= 1'b1;
                        last_rx      <= 1'b0;
                    end
                end

                RD_LOW: begin
                    if (cnt == '0) begin
                        rx_data        <= ft_data_in;
                        rx_valid       <= 1'b1;
                        FT_RD_Strobe_n <= 1'b1;
                        state          <= RD_HIGH;
                        cnt            <= RD_HIGH_LOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                RD_HIGH: begin
                    if (cnt == '0) begin
                        state      <= IDLE;
                        usb_active <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                WR_SETUP: begin
                    if (cnt == '0) begin
                        FT_WR_Strobe <= 1'b1;
                        state        <= WR_HIGH;
                        cnt          <= WR_HIGH_LOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                // The chip latches the byte on the falling edge of WR.
                WR_HIGH: begin
                    if (cnt == '0) begin
                        FT_WR_Strobe <= 1'b0;
                        state        <= WR_HOLD;
                        cnt          <= WR_HOLD_LOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                WR_HOLD: begin
                    ft_data_oe <= 1'b0;
                    if (cnt == '0) begin
                        state      <= IDLE;
                        usb_active <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                default: begin
                    state          <= IDLE;
                    cnt            <= '0;
                    FT_RD_Strobe_n <= 1'b1;
                    FT_WR_Strobe   <= 1'b0;
                    ft_data_oe     <= 1'b0;
                    usb_active     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft245_fifo_if.sv
// Self-checking bench for ft245_fifo_if: vector table, pin monitor with
// RX/TX byte scoreboards, and hand sequences for multi-cycle corner cases.
module tb_ft245_fifo_if;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       FT_RX_Full_n;
    logic       FT_TX_Enable_n;
    logic       FT_PWR_n;
    logic       FT_RD_Strobe_n;
    logic       FT_WR_Strobe;
    logic [7:0] ft_data_in;
    logic [7:0] ft_data_out;
    logic       ft_data_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       usb_active;
    logic       usb_power;

    ft245_fifo_if dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .FT_RX_Full_n   (FT_RX_Full_n),
        .FT_TX_Enable_n (FT_TX_Enable_n),
        .FT_PWR_n       (FT_PWR_n),
        .FT_RD_Strobe_n (FT_RD_Strobe_n),
        .FT_WR_Strobe   (FT_WR_Strobe),
        .ft_data_in     (ft_data_in),
        .ft_data_out    (ft_data_out),
        .ft_data_oe     (ft_data_oe),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .usb_active     (usb_active),
        .usb_power      (usb_power)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    bit         order_q[$];
    int         rd_falls = 0;
    int         wr_rises = 0;
    int         rd_len = 0;
    int         rd_high_len = 0;
    int         wr_len = 0;
    bit         had_read = 1'b0;
    bit         oe_watch = 1'b0;
    logic       prev_rd_n = 1'b1;
    logic       prev_wr = 1'b0;
    logic       prev_oe = 1'b0;
    logic [7:0] last_low_data = 8'h00;
    logic [7:0] exp_byte;

    typedef struct {
        string      name;
        logic       rxf_n;
        logic       txe_n;
        logic       pwr_n;
        logic       tv;
        logic       rr;
        logic [7:0] din;
        logic [7:0] txd;
        int         window;
        int         exp_rd;
        int         exp_wr;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic applyStimulus(input logic rxf_n, input logic txe_n, input logic pwr_n,
                                 input logic tv, input logic rr,
                                 input logic [7:0] din, input logic [7:0] txd);
        FT_RX_Full_n   = rxf_n;
        FT_TX_Enable_n = txe_n;
        FT_PWR_n       = pwr_n;
        tx_valid       = tv;
        rx_ready       = rr;
        ft_data_in     = din;
        tx_data        = txd;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitRdLow(output int n);
        n = 0;
        while (FT_RD_Strobe_n && n < 10) begin
            waitCycles(1);
            n++;
        end
    endtask

    task automatic waitTxReady(output int n);
        n = 0;
        while (!tx_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Pin monitor: bus exclusivity, strobe widths, and byte scoreboards.
    always @(negedge clk) begin
        if (!reset_n) begin
            rx_q.delete();
            tx_q.delete();
            rd_len   = 0;
            wr_len   = 0;
            had_read = 1'b0;
            oe_watch = 1'b0;
        end else begin
            checkOutput("rd_oe_exclusive", {31'b0, !FT_RD_Strobe_n && ft_data_oe}, 0);
            checkOutput("rd_wr_exclusive", {31'b0, !FT_RD_Strobe_n && FT_WR_Strobe}, 0);
            if (oe_watch) begin
                checkOutput("oe_drop_after_wr_fall", {31'b0, ft_data_oe}, 0);
                oe_watch = 1'b0;
            end

            if (!FT_RD_Strobe_n) begin
                if (prev_rd_n) begin
                    rd_falls++;
                    order_q.push_back(1'b1);
                    if (had_read) checkOutput("rd_recovery_ge3", {31'b0, rd_high_len >= 3}, 1);
                end
                rd_len++;
                last_low_data = ft_data_in;
            end else begin
                if (!prev_rd_n) begin
                    checkOutput("rd_low_len", rd_len, 5);
                    rx_q.push_back(last_low_data);
                    rd_len      = 0;
                    had_read    = 1'b1;
                    rd_high_len = 0;
                end
                rd_high_len++;
            end

            if (FT_WR_Strobe) begin
                if (!prev_wr) begin
                    wr_rises++;
                    order_q.push_back(1'b0);
                    checkOutput("wr_setup_oe", {31'b0, prev_oe}, 1);
                end
                wr_len++;
            end else if (prev_wr) begin
                checkOutput("wr_high_len", wr_len, 5);
                checkOutput("oe_at_wr_fall", {31'b0, ft_data_oe}, 1);
                if (tx_q.size() == 0) begin
                    checkOutput("tx_q_underflow", 1, 0);
                end else begin
                    exp_byte = tx_q.pop_front();
                    checkOutput("tx_byte", {24'b0, ft_data_out}, {24'b0, exp_byte});
                end
                wr_len   = 0;
                oe_watch = 1'b1;
            end

            if (tx_valid && tx_ready) tx_q.push_back(tx_data);

            if (rx_valid && rx_ready) begin
                if (rx_q.size() == 0) begin
                    checkOutput("rx_q_underflow", 1, 0);
                end else begin
                    exp_byte = rx_q.pop_front();
                    checkOutput("rx_byte", {24'b0, rx_data}, {24'b0, exp_byte});
                end
            end
        end
        prev_rd_n = FT_RD_Strobe_n;
        prev_wr   = FT_WR_Strobe;
        prev_oe   = ft_data_oe;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int rd0;
        int wr0;
        int idx;

        vecs[0] = '{"read_only",    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 8'h00, 40, 5, 0};
        vecs[1] = '{"write_only",   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h22, 40, 0, 4};
        vecs[2] = '{"power_off",    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 40, 0, 0};
        vecs[3] = '{"backpressure", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 8'h00, 40, 1, 0};
        vecs[4] = '{"both_pending", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 8'h77, 36, 2, 2};
        vecs[5] = '{"txe_no_valid", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h88, 20, 0, 0};

        // Reset with pins asserted: outputs idle, tx_ready held off by the synchronisers.
        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("reset_rd_n",       {31'b0, FT_RD_Strobe_n}, 1);
        checkOutput("reset_wr",         {31'b0, FT_WR_Strobe}, 0);
        checkOutput("reset_data_out",   {24'b0, ft_data_out}, 0);
        checkOutput("reset_oe",         {31'b0, ft_data_oe}, 0);
        checkOutput("reset_rx_data",    {24'b0, rx_data}, 0);
        checkOutput("reset_rx_valid",   {31'b0, rx_valid}, 0);
        checkOutput("reset_usb_active", {31'b0, usb_active}, 0);
        checkOutput("reset_usb_power",  {31'b0, usb_power}, 0);
        checkOutput("reset_tx_ready",   {31'b0, tx_ready}, 0);

        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        reset_n = 1'b1;
        waitCycles(5);

        $display("[TB] vector table");
        for (int i = 0; i < 6; i++) begin
            rd0 = rd_falls;
            wr0 = wr_rises;
            applyStimulus(vecs[i].rxf_n, vecs[i].txe_n, vecs[i].pwr_n, vecs[i].tv,
                          vecs[i].rr, vecs[i].din, vecs[i].txd);
            waitCycles(vecs[i].window);
            checkOutput({vecs[i].name, "_usb_power"}, {31'b0, usb_power}, {31'b0, !vecs[i].pwr_n});
            applyStimulus(1'b1, 1'b1, vecs[i].pwr_n, 1'b0, vecs[i].rr, vecs[i].din, vecs[i].txd);
            waitCycles(12);
            rx_ready = 1'b1;
            waitCycles(20);
            checkOutput({vecs[i].name, "_rd_pulses"}, rd_falls - rd0, vecs[i].exp_rd);
            checkOutput({vecs[i].name, "_wr_pulses"}, wr_rises - wr0, vecs[i].exp_wr);
        end

        $display("[TB] single read");
        rd0 = rd_falls;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00);
        waitRdLow(n);
        checkOutput("rd_latency", n, 3);
        waitCycles(3);
        ft_data_in   = 8'hA5;
        FT_RX_Full_n = 1'b1;
        waitCycles(2);
        checkOutput("read_rd_n_high", {31'b0, FT_RD_Strobe_n}, 1);
        checkOutput("read_rx_valid",  {31'b0, rx_valid}, 1);
        checkOutput("read_rx_data",   {24'b0, rx_data}, 32'hA5);
        waitCycles(1);
        checkOutput("read_rx_valid_one_cycle", {31'b0, rx_valid}, 0);
        waitCycles(15);
        checkOutput("read_single_pulse", rd_falls - rd0, 1);

        $display("[TB] backpressure");
        rd0 = rd_falls;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 8'h00);
        waitCycles(40);
        checkOutput("bp_one_pulse", rd_falls - rd0, 1);
        checkOutput("bp_rx_valid",  {31'b0, rx_valid}, 1);
        checkOutput("bp_rx_data",   {24'b0, rx_data}, 32'hC3);
        ft_data_in = 8'h3C;
        rx_ready   = 1'b1;
        waitCycles(2);
        FT_RX_Full_n = 1'b1;
        waitCycles(20);
        checkOutput("bp_second_pulse", rd_falls - rd0, 2);
        checkOutput("bp_next_byte",    {24'b0, rx_data}, 32'h3C);
        checkOutput("bp_drained",      {31'b0, rx_valid}, 0);

        $display("[TB] single write");
        wr0 = wr_rises;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h5A);
        waitTxReady(n);
        checkOutput("tx_ready_latency", n, 3);
        @(negedge clk);
        checkOutput("tx_ready_pulse",   {31'b0, tx_ready}, 0);
        checkOutput("wr_setup_oe_high", {31'b0, ft_data_oe}, 1);
        checkOutput("wr_setup_wr_low",  {31'b0, FT_WR_Strobe}, 0);
        checkOutput("wr_setup_data",    {24'b0, ft_data_out}, 32'h5A);
        checkOutput("wr_usb_active",    {31'b0, usb_active}, 1);
        @(posedge clk);
        #1;
        tx_valid       = 1'b0;
        FT_TX_Enable_n = 1'b1;
        waitCycles(15);
        checkOutput("write_single_pulse", wr_rises - wr0, 1);
        checkOutput("write_oe_released",  {31'b0, ft_data_oe}, 0);
        checkOutput("write_idle",         {31'b0, usb_active}, 0);

        $display("[TB] power loss mid-write");
        wr0 = wr_rises;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hE7);
        waitTxReady(n);
        checkOutput("pwr_tx_ready_latency", n, 3);
        @(posedge clk);
        #1;
        FT_PWR_n = 1'b1;
        waitCycles(30);
        checkOutput("pwr_write_completes", wr_rises - wr0, 1);
        checkOutput("pwr_usb_power_off",   {31'b0, usb_power}, 0);
        checkOutput("pwr_idle",            {31'b0, usb_active}, 0);
        checkOutput("pwr_tx_ready_off",    {31'b0, tx_ready}, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        waitCycles(5);

        $display("[TB] contention after reset");
        reset_n = 1'b0;
        waitCycles(2);
        reset_n = 1'b1;
        waitCycles(3);
        idx = order_q.size();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 8'h99);
        waitCycles(80);
        FT_RX_Full_n = 1'b1;
        waitCycles(5);
        tx_valid       = 1'b0;
        FT_TX_Enable_n = 1'b1;
        waitCycles(25);
        checkOutput("contention_count_ge6", {31'b0, (order_q.size() - idx) >= 6}, 1);
        for (int k = 0; k < 6; k++) begin
            if (idx + k < order_q.size()) begin
                checkOutput("contention_order", {31'b0, order_q[idx+k]}, {31'b0, (k % 2) == 0});
            end
        end

        $display("[TB] reset mid-read");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h42, 8'h00);
        waitRdLow(n);
        checkOutput("pre_reset_rd_latency", n, 3);
        waitCycles(2);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_rd_n",       {31'b0, FT_RD_Strobe_n}, 1);
        checkOutput("async_reset_oe",         {31'b0, ft_data_oe}, 0);
        checkOutput("async_reset_rx_valid",   {31'b0, rx_valid}, 0);
        checkOutput("async_reset_usb_active", {31'b0, usb_active}, 0);
        @(posedge clk);
        #1;
        waitCycles(2);
        reset_n = 1'b1;
        waitRdLow(n);
        checkOutput("post_reset_rd_latency", n, 3);
        FT_RX_Full_n = 1'b1;
        waitCycles(20);
        checkOutput("post_reset_rx_data", {24'b0, rx_data}, 32'h42);

        checkOutput("rx_scoreboard_empty", rx_q.size(), 0);
        checkOutput("tx_scoreboard_empty", tx_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ft245_fifo_if.md
Name: ft245_fifo_if

Overview:
- Byte-level front end for the FT245-style asynchronous USB FIFO. It sits between the FT chip pins and the USB packet/register engine, directly upstream of it.
- Generates the RD#/WR strobes with programmable timing and drives the data bus output enable; the top level builds the tristate buffer.
- Delivers received bytes on a valid/ready stream and accepts bytes to send on a second valid/ready stream.
- Interleaves RX and TX fairly when both directions are pending.

Parameters:
- RD_LOW_CYCLES, 5: clocks RD# is held low; data is sampled on the last one (50 ns at 100 MHz).
- RD_HIGH_CYCLES, 3: RD# high recovery before the next decision; minimum 3.
- WR_SETUP_CYCLES, 1: data driven with WR low, before WR rises.
- WR_HIGH_CYCLES, 5: WR held high.
- WR_HOLD_CYCLES, 3: WR low with data still driven, then recovery; minimum 3.
- SYNC_STAGES, 2: synchroniser depth for RXF#, TXE# and PWR#.

Ports:
- clk  in  1  system clock (100 MHz)
- reset_n  in  1  asynchronous, active-low reset
- FT_RX_Full_n  in  1  RXF#; low = byte available in the chip
- FT_TX_Enable_n  in  1  TXE#; low = chip can accept a byte
- FT_PWR_n  in  1  low = USB powered/configured
- FT_RD_Strobe_n  out  1  RD#, registered
- FT_WR_Strobe  out  1  WR, active high, registered
- ft_data_in  in  8  pad input
- ft_data_out  out  8  pad output, registered
- ft_data_oe  out  1  pad drive enable, registered
- rx_data  out  8  received byte
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_ready  in  1  consumer accepts the byte
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  byte taken this cycle (transfer = tx_valid & tx_ready)
- usb_active  out  1  a transaction is in progress
- usb_power  out  1  synchronised ~FT_PWR_n

Behaviour:
Reset values:
- FT_RD_Strobe_n=1, FT_WR_Strobe=0, ft_data_out=0, ft_data_oe=0.
- rx_data=0, rx_valid=0, usb_active=0, usb_power=0.
- State IDLE, counter 0.
- Synchroniser flops reset to the inactive level (1). tx_ready therefore reads 0 during reset.

Synchronisers:
- SYNC_STAGES flops on each of RXF#, TXE#, PWR#.
- rxf_ok = ~rxf_sync & pwr_ok & ~rx_valid.
- txe_ok = ~txe_sync & pwr_ok.

Arbitration (IDLE only):
- Only rxf_ok: go to read.
- Only txe_ok & tx_valid: go to write.
- Both pending: serve the direction not served last. A last_rx flag resets to 0, so RX wins first.

tx_ready:
- Combinational: IDLE & txe_ok & write granted this cycle.
- On transfer, tx_data is captured into ft_data_out.

State machine (counter reloads on every state entry):
- IDLE -> RD_LOW: RD# goes low on the next edge.
- RD_LOW (RD_LOW_CYCLES): on the final cycle, rx_data <= ft_data_in and rx_valid <= 1. RD# returns high on that same edge. -> RD_HIGH
- RD_HIGH (RD_HIGH_CYCLES): -> IDLE. The recovery covers sync latency, so a stale RXF# is never re-read.
- IDLE -> WR_SETUP: ft_data_oe=1, WR=0.
- WR_SETUP (WR_SETUP_CYCLES): -> WR_HIGH, WR=1.
- WR_HIGH (WR_HIGH_CYCLES): -> WR_HOLD, WR=0. The chip latches data on this falling edge.
- WR_HOLD (WR_HOLD_CYCLES): ft_data_oe stays 1 for the first cycle, then drops to 0. -> IDLE.

Other rules:
- usb_active = (state != IDLE), registered.
- rx_valid clears on rx_valid & rx_ready. A read is never started while rx_valid=1 (backpressure), so bytes are never dropped.
- Latency: RXF# falling -> RD# falling is SYNC_STAGES+1 clocks (3 by default). rx_valid rises RD_LOW_CYCLES clocks after RD# falls.
- ft_data_oe and RD# low are mutually exclusive at all times. RD# low and WR high never coexist.

Power loss (pwr_ok drops mid-transaction):
- The current state runs to completion. No new transaction starts.
- rx_valid and rx_data are retained.

Asynchronous reset mid-transaction:
- All outputs take their reset values immediately. The bus is released and the strobes are deasserted.

Counter:
- Width is $clog2(max timing parameter + 1).
- Zero-valued timing parameters are illegal; elaboration asserts each is >= 1, and that RD_HIGH_CYCLES and WR_HOLD_CYCLES are >= SYNC_STAGES+1.

Decomposition:
- Skeleton_package gets:
  - typedef enum ft_state_t {IDLE, RD_LOW, RD_HIGH, WR_SETUP, WR_HIGH, WR_HOLD}
  - constants FT_RD_LOW_CYCLES, FT_RD_HIGH_CYCLES, FT_WR_SETUP_CYCLES, FT_WR_HIGH_CYCLES, FT_WR_HOLD_CYCLES, FT_SYNC_STAGES, used as parameter defaults.
- Sub-module: sync_ff (parameterised depth and reset value), instantiated three times.
- The FSM, counter and arbiter stay in ft245_fifo_if.

Test Plan:
1. Single read: FT_PWR_n=0, RXF# low, ft_data_in=0xA5, rx_ready=1.
   -> RD# low 3 clocks after RXF# falls, for 5 clocks.
   -> rx_data=0xA5 with rx_valid=1 for one cycle.
   -> RD# high for at least 3 clocks.
2. Backpressure: RXF# held low, rx_ready=0.
   -> Exactly one RD# pulse; no further pulse until rx_ready=1.
   -> Then the next byte 0x3C is read.
3. Single write: TXE# low, tx_valid=1, tx_data=0x5A.
   -> tx_ready pulses 1 clock.
   -> oe=1, WR low 1 clock, then high 5 clocks with ft_data_out=0x5A.
   -> oe drops 1 clock after WR falls.
4. Contention: RXF#, TXE# low and tx_valid=1 continuously.
   -> Transactions alternate RX, TX, RX, TX, starting with RX after reset.
   -> RD# low and WR high never overlap.
5. Power gating: FT_PWR_n=1 with RXF#/TXE# low.
   -> No strobes, usb_power=0.
   -> Raising FT_PWR_n mid-write lets that write complete, then the block idles.
6. Reset mid-read: reset_n low during RD_LOW.
   -> RD#=1, oe=0, rx_valid=0 asynchronously.
   -> After release, a new read starts 3 clocks after the sync chain sees RXF#.
